// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Pipeline stall-bus layout, FSM state encodings and the divide-by-zero quotient.
package mdu_ctrl_pkg;

  localparam int STALL_W      = 6;
  localparam int EX_STALL_BIT = 2;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;

  // Two's-complement negate when neg is set; used for magnitudes and sign restore.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// A start pulse latches operands; done pulses in the cycle the final bit is produced.
module mdu_ctrl_div_core
  import mdu_ctrl_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [32:0]      shifted;
  logic [32:0]      diff;

  assign shifted = {rem_q, quot_q[31]};
  assign diff    = shifted - {1'b0, divisor_q};

  always_comb begin
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (start_i) begin
      rem_d     = '0;
      quot_d    = dividend_i;
      divisor_d = divisor_i;
      cnt_d     = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      // Partial remainder stays below the divisor, so 32 bits always hold it.
      if (!diff[32]) begin
        rem_d  = diff[31:0];
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = shifted[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer; sole producer of HI/LO writes.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; division is iterative in both builds.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DIV_STEPS = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               inst_mult,
  input  logic               inst_multu,
  input  logic               inst_div,
  input  logic               inst_divu,
  input  logic               inst_mthi,
  input  logic               inst_mtlo,
  input  logic [31:0]        src1,
  input  logic [31:0]        src2,
  output logic               stallreq_for_ex,
  output logic               hi_we,
  output logic               lo_we,
  output logic [31:0]        hi_out,
  output logic [31:0]        lo_out
);

  localparam int MAX_STEPS = (DIV_STEPS > MUL_STEPS) ? DIV_STEPS : MUL_STEPS;
  localparam int CNT_W     = $clog2(MAX_STEPS) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, neg_res_q, sign_a_q, div_zero_q;
  logic [63:0]      prod_q;

  logic        div_req, mul_req, op_signed;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic        issue, div_start, mul_issue;
  logic        busy_c;
  logic        div_busy, div_done;
  logic [31:0] div_quot, div_rem;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, res_hi, res_lo;
  logic        unused_stall;

  // Only the EX bit of the stall bus matters here.
  assign unused_stall = ^{stall[STALL_W-1:EX_STALL_BIT+1], stall[EX_STALL_BIT-1:0]};

  // Fixed priority if decode ever breaks one-hot: div > divu > mult > multu.
  assign div_req   = inst_div | inst_divu;
  assign mul_req   = ~div_req & (inst_mult | inst_multu);
  assign op_signed = inst_div | (~inst_divu & inst_mult);
  assign sign_a    = op_signed & src1[31];
  assign sign_b    = op_signed & src2[31];
  assign mag_a     = mag32(src1, sign_a);
  assign mag_b     = mag32(src2, sign_b);

  assign issue     = (state_q == MDU_IDLE) & (div_req | mul_req);
  assign div_start = issue & div_req;
  assign mul_issue = issue & mul_req;

  mdu_ctrl_div_core #(
    .STEPS(DIV_STEPS)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(mag_a),
    .divisor_i (mag_b),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_c  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        cnt_d = '0;
        if (div_req) begin
          busy_c  = 1'b1;
          state_d = MDU_DIV;
        end else if (mul_req) begin
          busy_c  = 1'b1;
`ifdef MDU_FAST_MUL_EN
          state_d = MDU_DONE;
`else
          state_d = MDU_MUL;
`endif
        end
      end
      MDU_MUL: begin
        busy_c = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) state_d = MDU_DONE;
      end
      MDU_DIV: begin
        busy_c = div_busy;
        if (div_done) state_d = MDU_DONE;
      end
      MDU_DONE: begin
        if (stall[EX_STALL_BIT] == NO_STOP) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MDU_IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      sign_a_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        op_div_q   <= div_req;
        neg_res_q  <= sign_a ^ sign_b;
        sign_a_q   <= sign_a;
        div_zero_q <= div_req & (src2 == 32'd0);
      end
    end
  end

`ifdef MDU_FAST_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else if (mul_issue) begin
      prod_q <= {32'd0, mag_a} * {32'd0, mag_b};
    end
  end
`else
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;

  // Shift-add: one multiplier bit per MUL_RUN cycle, LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (mul_issue) begin
      prod_q   <= '0;
      mcand_q  <= {32'd0, mag_a};
      mplier_q <= mag_b;
    end else if (state_q == MDU_MUL) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
`endif

  assign prod_fix = neg_res_q ? (64'd0 - prod_q) : prod_q;
  assign quot_fix = div_zero_q ? DIV_ZERO_QUOT : mag32(div_quot, neg_res_q);
  assign rem_fix  = mag32(div_rem, sign_a_q);
  assign res_hi   = op_div_q ? rem_fix  : prod_fix[63:32];
  assign res_lo   = op_div_q ? quot_fix : prod_fix[31:0];

  always_comb begin
    stallreq_for_ex = 1'b0;
    hi_we           = 1'b0;
    lo_we           = 1'b0;
    hi_out          = '0;
    lo_out          = '0;
    if (!rst) begin
      stallreq_for_ex = busy_c;
      if (state_q == MDU_DONE) begin
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        hi_out = res_hi;
        lo_out = res_lo;
      end else if ((state_q == MDU_IDLE) && !div_req && !mul_req) begin
        if (inst_mthi) begin
          hi_we  = 1'b1;
          hi_out = src1;
        end else if (inst_mtlo) begin
          lo_we  = 1'b1;
          lo_out = src1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: reset, multiply, divide corner cases, MTHI/MTLO,
// DONE hold under external stall, and reset in the middle of an operation.
module tb_mdu_ctrl;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        inst_mult, inst_multu, inst_div, inst_divu, inst_mthi, inst_mtlo;
  logic [31:0] src1, src2;
  logic        stallreq_for_ex, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;   // {multu, mult, divu, div}
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  mdu_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .inst_mult      (inst_mult),
    .inst_multu     (inst_multu),
    .inst_div       (inst_div),
    .inst_divu      (inst_divu),
    .inst_mthi      (inst_mthi),
    .inst_mtlo      (inst_mtlo),
    .src1           (src1),
    .src2           (src2),
    .stallreq_for_ex(stallreq_for_ex),
    .hi_we          (hi_we),
    .lo_we          (lo_we),
    .hi_out         (hi_out),
    .lo_out         (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inst();
    inst_mult  = 1'b0;
    inst_multu = 1'b0;
    inst_div   = 1'b0;
    inst_divu  = 1'b0;
    inst_mthi  = 1'b0;
    inst_mtlo  = 1'b0;
  endtask

  // Issues one op, counts stall cycles (bounded), returns DONE-cycle outputs.
  // Operands are scrambled after issue; the request is dropped in the DONE cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic hwe, output logic lwe,
                        output logic [31:0] hi, output logic [31:0] lo);
    @(posedge clk);
    #1;
    stall      = 6'b0;
    inst_div   = op[0];
    inst_divu  = op[1];
    inst_mult  = op[2];
    inst_multu = op[3];
    src1       = a;
    src2       = b;
    #1;
    cyc = 0;
    while (stallreq_for_ex && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #1;
      src1 = ~a;
      src2 = ~b;
      #1;
    end
    hwe = hi_we;
    lwe = lo_we;
    hi  = hi_out;
    lo  = lo_out;
    clear_inst();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 6'b0;
    clear_inst();
    src1 = 32'h1111_2222;
    src2 = 32'h3333_4444;
    repeat (2) @(posedge clk);
    #1;
    inst_mthi = 1'b1;
    #1;
    total++;
    if (stallreq_for_ex !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 ||
        hi_out !== 32'd0 || lo_out !== 32'd0)
      $display("FAIL reset_outputs: got stall=%b hwe=%b lwe=%b hi=%h lo=%h, want all 0",
               stallreq_for_ex, hi_we, lo_we, hi_out, lo_out);
    clear_inst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (stallreq_for_ex !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0)
      $display("FAIL reset_idle: got stall=%b hwe=%b lwe=%b, want 0 0 0",
               stallreq_for_ex, hi_we, lo_we);
    $display("reset: stall=%b hwe=%b lwe=%b", stallreq_for_ex, hi_we, lo_we);
  endtask

  task automatic check_vec(input string name, input vec_t v);
    int          cyc;
    logic        hwe, lwe;
    logic [31:0] hi, lo;
    run_op(v.op, v.a, v.b, cyc, hwe, lwe, hi, lo);
    $display("%s op=%b a=%h b=%h cyc=%0d hi=%h lo=%h", name, v.op, v.a, v.b, cyc, hi, lo);
    total++;
    if (cyc !== v.lat)
      $display("FAIL %s_latency: got %0d stall cycles, want %0d", name, cyc, v.lat);
    total++;
    if (hwe !== 1'b1 || lwe !== 1'b1)
      $display("FAIL %s_we: got hwe=%b lwe=%b, want 1 1", name, hwe, lwe);
    total++;
    if (hi !== v.hi || lo !== v.lo)
      $display("FAIL %s_result: got hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, v.hi, v.lo);
    if (cyc !== v.lat || hwe !== 1'b1 || lwe !== 1'b1 || hi !== v.hi || lo !== v.lo) bad++;
  endtask

  task automatic test_multiply();
    vec_t tab[4];
    tab[0] = '{4'b0100, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
    tab[1] = '{4'b1000, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT};
    tab[2] = '{4'b0100, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, MUL_LAT};
    tab[3] = '{4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT};
    for (int i = 0; i < 4; i++) check_vec($sformatf("mul%0d", i), tab[i]);
  endtask

  task automatic test_divide();
    vec_t tab[8];
    tab[0] = '{4'b0010, 32'd100,        32'd7,         32'd2,         32'd14,        DIV_LAT};
    tab[1] = '{4'b0001, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    tab[2] = '{4'b0001, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT};
    tab[3] = '{4'b0001, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_LAT};
    tab[4] = '{4'b0001, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT};
    tab[5] = '{4'b0010, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, DIV_LAT};
    tab[6] = '{4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT};
    tab[7] = '{4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         DIV_LAT};
    for (int i = 0; i < 8; i++) check_vec($sformatf("div%0d", i), tab[i]);
  endtask

  // div and mult both asserted: div must win (-7 / 2 signed).
  task automatic test_priority();
    vec_t v;
    v = '{4'b0101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    check_vec("prio", v);
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    inst_mthi = 1'b1;
    src1 = 32'h1234_5678;
    #1;
    total++;
    if (stallreq_for_ex !== 1'b0 || hi_we !== 1'b1 || lo_we !== 1'b0 || hi_out !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mthi: got stall=%b hwe=%b lwe=%b hi=%h, want 0 1 0 12345678",
               stallreq_for_ex, hi_we, lo_we, hi_out);
    end
    $display("mthi: hwe=%b hi=%h", hi_we, hi_out);
    @(posedge clk);
    #1;
    inst_mthi = 1'b0;
    inst_mtlo = 1'b1;
    src1 = 32'h9ABC_DEF0;
    #1;
    total++;
    if (stallreq_for_ex !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b1 || lo_out !== 32'h9ABC_DEF0) begin
      bad++;
      $display("FAIL mtlo: got stall=%b hwe=%b lwe=%b lo=%h, want 0 0 1 9abcdef0",
               stallreq_for_ex, hi_we, lo_we, lo_out);
    end
    $display("mtlo: lwe=%b lo=%h", lo_we, lo_out);
    @(posedge clk);
    #1;
    clear_inst();
    #1;
    total++;
    if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
      bad++;
      $display("FAIL move_idle: got hwe=%b lwe=%b, want 0 0", hi_we, lo_we);
    end
  endtask

  task automatic test_done_hold();
    int          cyc;
    logic        hwe, lwe;
    logic [31:0] hi, lo;
    run_op(4'b0010, 32'd1000, 32'd3, cyc, hwe, lwe, hi, lo);
    $display("hold_issue: cyc=%0d hi=%h lo=%h", cyc, hi, lo);
    total++;
    if (cyc !== DIV_LAT || hi !== 32'd1 || lo !== 32'd333) begin
      bad++;
      $display("FAIL hold_result: got cyc=%0d hi=%h lo=%h, want %0d 1 333", cyc, hi, lo, DIV_LAT);
    end
    stall      = 6'b000111;
    inst_mult  = 1'b1;
    src1       = 32'hDEAD_BEEF;
    src2       = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      total++;
      if (hi_we !== 1'b1 || lo_we !== 1'b1 || hi_out !== 32'd1 || lo_out !== 32'd333 ||
          stallreq_for_ex !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got hwe=%b lwe=%b hi=%h lo=%h stall=%b, want 1 1 1 14d 0",
                 i, hi_we, lo_we, hi_out, lo_out, stallreq_for_ex);
      end
      $display("hold_cycle%0d: hi=%h lo=%h", i, hi_out, lo_out);
    end
    clear_inst();
    stall = 6'b0;
    @(posedge clk);
    #2;
    total++;
    if (hi_we !== 1'b0 || lo_we !== 1'b0 || stallreq_for_ex !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: got hwe=%b lwe=%b stall=%b, want 0 0 0",
               hi_we, lo_we, stallreq_for_ex);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    stall     = 6'b0;
    inst_mult = 1'b1;
    src1      = 32'd5;
    src2      = 32'd6;
    repeat (10) @(posedge clk);
    #2;
    total++;
    if (stallreq_for_ex !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_running: got stall=%b, want 1", stallreq_for_ex);
    end
    rst = 1'b1;
    clear_inst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (stallreq_for_ex !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle: got stall=%b hwe=%b lwe=%b, want 0 0 0",
               stallreq_for_ex, hi_we, lo_we);
    end
    inst_mtlo = 1'b1;
    src1 = 32'h0000_CAFE;
    #1;
    total++;
    if (lo_we !== 1'b1 || lo_out !== 32'h0000_CAFE || stallreq_for_ex !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_mtlo: got lwe=%b lo=%h stall=%b, want 1 0000cafe 0",
               lo_we, lo_out, stallreq_for_ex);
    end
    $display("rst_mid: stall=%b lwe=%b lo=%h", stallreq_for_ex, lo_we, lo_out);
    clear_inst();
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_priority();
    test_back_to_back();
    test_done_hold();
    test_reset_mid();
    // Operation after a mid-run reset must still work.
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and raises an EX stall request while an iterative operation runs.
- On completion, drives the HI/LO write enables and data that travel down EX/MEM/WB to the HI/LO register. This is the sole producer of HI/LO writes.

Parameters:
- DIV_STEPS, 32, quotient bits produced (one per cycle).
- MUL_STEPS, 32, shift-add iterations for the iterative multiplier.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  `StallBus  pipeline stall vector; bit 2 = EX.
- inst_mult, inst_multu, inst_div, inst_divu  in  1 each  one-hot op valid in EX.
- inst_mthi, inst_mtlo  in  1 each  move-to-HI/LO valid in EX.
- src1  in  32  rs operand (dividend / multiplicand / move data).
- src2  in  32  rt operand (divisor / multiplier).
- stallreq_for_ex  out  1  combinational EX stall request.
- hi_we, lo_we  out  1 each  HI/LO write enables for this EX instruction.
- hi_out, lo_out  out  32 each  HI/LO write data.

Behaviour:
- Reset: state IDLE, counter 0, working regs 0; all outputs 0.
- States and transitions:
  - IDLE → MUL_RUN on a mult/multu request.
  - IDLE → DIV_RUN on a div/divu request.
  - MUL_RUN → DONE when counter = MUL_STEPS-1.
  - DIV_RUN → DONE when counter = DIV_STEPS-1.
  - DONE → IDLE when stall[2] == `NoStop; otherwise hold DONE.
- stallreq_for_ex:
  - 1 in IDLE when a mult/multu/div/divu request is present.
  - 1 throughout MUL_RUN and DIV_RUN.
  - 0 in DONE and for all other cases.
- Latency: issue cycle plus 32 RUN cycles, then DONE. The instruction is held in EX for 33 cycles and advances in DONE.
- DONE outputs:
  - hi_we = lo_we = 1, hi_out/lo_out = result.
  - Held stable while stall[2] == `Stop from another source.
- MTHI / MTLO:
  - Handled in IDLE with no stall.
  - Same cycle: hi_we = 1, hi_out = src1 (MTHI); or lo_we = 1, lo_out = src1 (MTLO). The other enable is 0.
- Operand latching: on issue, latch |src1|, |src2| (signed ops) or raw values (unsigned ops), plus the sign flags. Later changes on src1/src2 are ignored.
- Multiply: 64-bit shift-add on magnitudes; the product is negated if signs differ (signed only). HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring radix-2 division on magnitudes.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero: no trap. LO = 0xFFFFFFFF, HI = dividend magnitude (sign-restored for DIV).
- 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0. The magnitude 2^31 is handled as unsigned 32-bit.
- Simultaneous requests: one-hot is guaranteed by decode. Priority if violated: div > divu > mult > multu > mthi > mtlo.
- Requests arriving while not IDLE: ignored (EX is stalled, so the instruction is still the one in flight).
- rst mid-operation: returns to IDLE next edge, result discarded, stallreq drops.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle `*` product.
  - Operands are registered; state goes IDLE → DONE directly.
  - Stall is 1 cycle (the issue cycle only); results in DONE as above.
- MDU_FAST_MUL_EN undefined: iterative MUL_RUN path, 33-cycle latency.
- Divide behaviour is identical in both builds.

Decomposition:
- lib/defines.vh holds:
  - `StallBus, `Stop, `NoStop.
  - State encodings MDU_IDLE / MDU_MUL / MDU_DIV / MDU_DONE (2-bit).
  - `DivZeroQuot = 32'hFFFFFFFF.
- One natural sub-module, div_core:
  - Holds the iterative restoring divider datapath: remainder/quotient shift regs and counter.
  - Controlled by start/busy/done.
  - mdu_ctrl keeps the FSM, sign handling, multiplier and output muxing.

Test Plan:
- MULT src1 = 0xFFFFFFFE (-2), src2 = 3 → stallreq high 33 cycles; DONE: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- DIVU 100 / 7 → DONE after 33 cycles: LO = 14, HI = 2. DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV by 0 with src1 = 5 → LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back → no stall; hi_we then lo_we each for one cycle with the given data.
- DIVU issued, stall[2] held `Stop 3 extra cycles at DONE → outputs unchanged over those cycles; IDLE after release.
- rst asserted at RUN cycle 10 → next cycle IDLE, stallreq = 0, hi_we = lo_we = 0. With MDU_FAST_MUL_EN, MULTU 0xFFFFFFFF × 2 → 1-cycle stall; HI = 1, LO = 0xFFFFFFFE.
